// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Bits needed to hold values 0..v-1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division step: shift in the next dividend bit, subtract if it fits.
module divider_step #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_o
);

  // One bit wider than the operands so the compare cannot overflow
  logic [DATA_WIDTH:0] trial;

  assign trial = {rem_i, bit_i};
  assign q_o   = (trial >= {1'b0, divisor_i});
  assign rem_o = q_o ? DATA_WIDTH'(trial - {1'b0, divisor_i}) : trial[DATA_WIDTH-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider with Start/Ready handshake, one quotient bit per clock.
// Define SEQUENTIAL_DIVIDER_SIGNED_EN for two's-complement (truncating) division.
module sequential_divider
  import divider_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  nRst,
  input  logic [DATA_WIDTH-1:0] Dividend,
  input  logic [DATA_WIDTH-1:0] Divisor,
  input  logic                  Start,
  output logic [DATA_WIDTH-1:0] Quotient,
  output logic [DATA_WIDTH-1:0] Remainder,
  output logic                  Ready,
  output logic                  DivByZero
);

  localparam int unsigned CNT_W = clog2(DATA_WIDTH + 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] remo_q, remo_d;
  logic                  dbz_q, dbz_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic neg,
                                                     input logic [DATA_WIDTH-1:0] x);
    return neg ? DATA_WIDTH'(-x) : x;
  endfunction
`endif

  divider_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DATA_WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b1;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      ready_q <= ready_d;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ready_d = ready_q;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          rem_d   = '0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
          negr_d  = Dividend[DATA_WIDTH-1];
          negq_d  = Dividend[DATA_WIDTH-1] ^ Divisor[DATA_WIDTH-1];
          dvd_d   = cond_neg(Dividend[DATA_WIDTH-1], Dividend);
          dsr_d   = cond_neg(Divisor[DATA_WIDTH-1], Divisor);
`else
          dvd_d   = Dividend;
          dsr_d   = Divisor;
`endif
          state_d = (Divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DATA_WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        ready_d = 1'b1;
        // On divide by zero dvd_q still holds the (absolute) dividend
        if (dsr_q == '0) begin
          quot_d = '1;
          dbz_d  = 1'b1;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
          remo_d = cond_neg(negr_q, dvd_q);
`else
          remo_d = dvd_q;
`endif
        end else begin
          dbz_d  = 1'b0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
          quot_d = cond_neg(negq_q, dvd_q);
          remo_d = cond_neg(negr_q, rem_q);
`else
          quot_d = dvd_q;
          remo_d = rem_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Quotient  = quot_q;
  assign Remainder = remo_q;
  assign DivByZero = dbz_q;
  assign Ready     = ready_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: directed cases plus random operands vs. arithmetic model.
module tb_sequential_divider;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         Clk = 1'b0;
  logic         nRst;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic         Start;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Ready;
  logic         DivByZero;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  sequential_divider #(.DATA_WIDTH(W)) dut (
    .Clk       (Clk),
    .nRst      (nRst),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Start     (Start),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Ready     (Ready),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.lat = (b == '0) ? 1 : W + 1;
    e.dbz = (b == '0);
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    begin
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sb == 0) begin
        e.q = '1;
        e.r = a;
      end else if (sa == -(1 << (W - 1)) && sb == -1) begin
        e.q = a;
        e.r = '0;
      end else begin
        e.q = W'(sa / sb);
        e.r = W'(sa % sb);
      end
    end
`else
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Monitor: compare on every Ready rise, check latency and output hold while busy
  initial begin
    logic         prev;
    int           lowc;
    logic         changed;
    logic [W-1:0] sq, sr;
    logic         sd;
    exp_t         e;
    prev = 1'b1; lowc = 0; changed = 1'b0;
    sq = '0; sr = '0; sd = 1'b0;
    forever begin
      @(negedge Clk);
      if (!nRst) begin
        prev = 1'b1; lowc = 0; changed = 1'b0;
      end else begin
        if (!Ready) begin
          if (prev) begin
            sq = Quotient; sr = Remainder; sd = DivByZero; changed = 1'b0;
          end else if (Quotient != sq || Remainder != sr || DivByZero != sd) begin
            changed = 1'b1;
          end
          lowc++;
        end else if (!prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("quotient", longint'(Quotient), longint'(e.q));
            chk("remainder", longint'(Remainder), longint'(e.r));
            chk("divbyzero", longint'(DivByZero), longint'(e.dbz));
            chk("ready_low_cycles", longint'(lowc), longint'(e.lat));
            chk("hold_while_busy", longint'(changed), 0);
          end
          lowc = 0;
        end
        prev = Ready;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!Ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!Ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge Clk);
    Start = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    logic [W-1:0] a, b;
    nRst = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
    #12;
    chk("reset_ready", longint'(Ready), 1);
    chk("reset_quotient", longint'(Quotient), 0);
    chk("reset_remainder", longint'(Remainder), 0);
    chk("reset_dbz", longint'(DivByZero), 0);
    @(negedge Clk);
    nRst = 1'b1;
    @(negedge Clk);

    do_op(16'd20, 16'd4);

    // Back-to-back with Start held high across completion
    wait_ready();
    Dividend = 16'd100; Divisor = 16'd7; Start = 1'b1;
    exp_q.push_back(model(16'd100, 16'd7));
    @(negedge Clk);
    Dividend = 16'hFFFF; Divisor = 16'd1;
    exp_q.push_back(model(16'hFFFF, 16'd1));
    wait_ready();
    hi = 0;
    n = 0;
    while (Ready && n < 10) begin
      hi++; n++;
      @(negedge Clk);
    end
    chk("b2b_ready_high_cycles", longint'(hi), 1);
    Start = 1'b0;

    do_op(16'd9, 16'd0);
    do_op(16'd3, 16'd5);

    // Start pulse while busy must be ignored
    do_op(16'd50, 16'd3);
    repeat (5) @(negedge Clk);
    Dividend = 16'd77; Divisor = 16'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;

    // Reset mid-operation aborts at once
    wait_ready();
    Dividend = 16'd1000; Divisor = 16'd10; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    @(posedge Clk);
    #2 nRst = 1'b0;
    #1;
    chk("abort_ready", longint'(Ready), 1);
    chk("abort_quotient", longint'(Quotient), 0);
    chk("abort_remainder", longint'(Remainder), 0);
    chk("abort_dbz", longint'(DivByZero), 0);
    @(negedge Clk);
    nRst = 1'b1;
    @(negedge Clk);
    do_op(16'd1000, 16'd10);

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    do_op(16'hFFF9, 16'd2);
    do_op(16'd7, 16'hFFFE);
    do_op(16'h8000, 16'hFFFF);
    do_op(16'h8000, 16'd0);
`endif

    do_op(16'd5, 16'd9);
    do_op(16'd0, 16'd1);
    do_op(16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      do_op(a, b);
    end

    wait_ready();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Multi-cycle restoring integer divider; the inverse of the team's Multiplier block.
- Uses the same Start/Ready handshake, so datapath controllers and benches can drive both blocks identically.
- Computes quotient and remainder of an unsigned (optionally signed) DATA_WIDTH-bit division, one quotient bit per clock.
- Sits beside the Multiplier in the arithmetic component library.

Parameters:
- DATA_WIDTH, 16, operand and result width in bits (>= 2).

Ports:
- Clk  input  1  system clock; all state is updated on the rising edge.
- nRst  input  1  asynchronous, active-low reset.
- Dividend  input  DATA_WIDTH  numerator; sampled when a start is accepted.
- Divisor  input  DATA_WIDTH  denominator; sampled when a start is accepted.
- Start  input  1  request; level-sensitive, accepted only while Ready=1.
- Quotient  output  DATA_WIDTH  result quotient; held until the next completion.
- Remainder  output  DATA_WIDTH  result remainder; held until the next completion.
- Ready  output  1  1 = idle and results valid; 0 = busy.
- DivByZero  output  1  set with the results when the accepted Divisor was 0.

Behaviour:
- Reset (nRst=0, asynchronous):
  - state=IDLE, Ready=1.
  - Quotient=0, Remainder=0, DivByZero=0.
  - Counter and working registers cleared.
- A reset asserted mid-operation aborts immediately; no partial result is ever exposed.
- States:
  - IDLE: Ready=1. On a rising edge with Start=1, latch the operands and clear the count.
    - Divisor==0 → FIX.
    - Otherwise → CALC.
  - CALC: Ready=0. Each cycle:
    - Shift {rem, dividend} left by 1.
    - If rem >= Divisor: subtract Divisor and shift 1 into the quotient; otherwise shift 0.
    - Count runs 0..DATA_WIDTH-1; after DATA_WIDTH cycles → FIX.
  - FIX: Ready=0 for one cycle. Register Quotient, Remainder and DivByZero → IDLE.
- Latency: Ready falls on the edge that accepts Start.
  - Normal operation: results are valid and Ready rises DATA_WIDTH+1 cycles later.
  - Divide by zero: results are valid and Ready rises 1 cycle later.
- Handshake:
  - Start while Ready=0 is ignored.
  - Start still high when Ready returns to 1 begins a new operation on the next edge, with operands resampled. The master drops Start after seeing Ready=0.
  - Outputs change only on the FIX→IDLE edge (or on reset).
- Arithmetic:
  - Working remainder register is DATA_WIDTH+1 bits wide, so the compare never overflows.
  - Quotient and Remainder are truncated to DATA_WIDTH bits.
  - Dividend < Divisor gives Quotient=0, Remainder=Dividend.
- Divide by zero: Quotient = all ones, Remainder = Dividend, DivByZero=1.
  - DivByZero clears at the next non-zero-divisor completion.

Optional Feature:
- Macro: SEQUENTIAL_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - IDLE latches the absolute values and records the sign flags.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative, so the remainder takes the dividend's sign (truncating division).
  - Overflow MIN/-1: Quotient=MIN, Remainder=0.
  - Divide by zero: Quotient=-1 (all ones), Remainder=Dividend.
  - Latency is unchanged.
- Undefined: purely unsigned operation; no sign logic is synthesised.

Decomposition:
- Package divider_pkg contains:
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - The counter width function clog2(DATA_WIDTH+1).
- One natural sub-module, divider_step: a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- The top level holds the FSM, counter and registers.

Test Plan:
- Reset, then Dividend=20, Divisor=4 → Ready low exactly 17 cycles (DATA_WIDTH=16); Quotient=5, Remainder=0, DivByZero=0.
- 100/7, then back-to-back 0xFFFF/1 with Start held high → first op gives 14 r 2; second starts the cycle after Ready rises and gives 0xFFFF r 0.
- 9/0 → Ready low 1 cycle; Quotient=0xFFFF, Remainder=9, DivByZero=1. Then 3/5 → 0 r 3, DivByZero=0.
- Start 50/3; change operands and pulse Start mid-CALC → ignored, result 16 r 2.
- Start 1000/10; assert nRst during cycle 8 → Ready=1 and outputs 0 asynchronously. Next 1000/10 → 100 r 0.
- (SIGNED_EN) -7/2 → -3 r -1; 7/-2 → -3 r 1; 0x8000/0xFFFF → 0x8000 r 0.
